// File: rtl/fact_arb_if.sv
// fact_arb_if: requester-side and engine-side signal bundle for fact_arb.
// slave  = the arbiter's view (drives grant/response and engine command).
// master = the surrounding environment's view (requesters plus engine).
interface fact_arb_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4
);
    // Requester side
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_n;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_nf;
    logic                  resp_err;

    // Engine side
    logic [WIDTH-1:0]      fact_n;
    logic                  fact_go;
    logic                  fact_done;
    logic                  fact_err;
    logic [WIDTH-1:0]      fact_nf;
    logic                  fact_abort;

    modport slave (
        input  req, req_n, fact_done, fact_err, fact_nf,
        output grant, resp_valid, resp_nf, resp_err, fact_n, fact_go, fact_abort
    );

    modport master (
        output req, req_n, fact_done, fact_err, fact_nf,
        input  grant, resp_valid, resp_nf, resp_err, fact_n, fact_go, fact_abort
    );
endinterface

// File: rtl/fact_arb.sv
// fact_arb: round-robin arbiter/sequencer sharing one factorial engine
// among NREQ requesters. One request is outstanding at the engine at a time.
// Optional engine watchdog: define FACT_ARB_TIMEOUT_EN to enable the WAIT
// cycle counter and fact_abort; otherwise fact_abort stays 0.
module fact_arb #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic       clk,
    input logic       rst,
    fact_arb_if.slave bus
);
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("fact_arb: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    state_t           state;
    logic [IDXW-1:0]  rr;
    logic [IDXW-1:0]  win_idx;
    logic [NREQ-1:0]  grant_q;
    logic [NREQ-1:0]  resp_valid_q;
    logic [WIDTH-1:0] resp_nf_q;
    logic             resp_err_q;
    logic [WIDTH-1:0] fact_n_q;
    logic             fact_go_q;
    logic             fact_abort_q;

    logic [WIDTH-1:0] req_ops [NREQ];
    logic             pick_found;
    logic [IDXW-1:0]  pick_idx;
    logic [NREQ-1:0]  pick_onehot;
    logic [WIDTH-1:0] pick_n;
    logic [IDXW-1:0]  cand;
    logic             wait_expired;

    for (genvar i = 0; i < int'(NREQ); i++) begin : g_ops
        assign req_ops[i] = bus.req_n[i*WIDTH +: WIDTH];
    end

    // Round-robin pick: first asserted request at or after rr, wrapping.
    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        pick_n      = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDXW'((32'(rr) + k) % NREQ);
            if (!pick_found && bus.req[cand]) begin
                pick_found        = 1'b1;
                pick_idx          = cand;
                pick_onehot[cand] = 1'b1;
                pick_n            = req_ops[cand];
            end
        end
    end

`ifdef FACT_ARB_TIMEOUT_EN
    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] wait_cnt;

    // Expiry fires on the TIMEOUT-th WAIT cycle without done, so the count
    // would reach TIMEOUT at that edge; done in that same cycle still wins.
    assign wait_expired = (wait_cnt == CNTW'(TIMEOUT - 1));

    // WAIT-cycle watchdog counter, restarted for every issued operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !bus.fact_done) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    // Arbiter/sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr           <= '0;
            win_idx      <= '0;
            grant_q      <= '0;
            resp_valid_q <= '0;
            resp_nf_q    <= '0;
            resp_err_q   <= 1'b0;
            fact_n_q     <= '0;
            fact_go_q    <= 1'b0;
            fact_abort_q <= 1'b0;
        end else begin
            fact_go_q    <= 1'b0;
            resp_valid_q <= '0;
            fact_abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_q   <= pick_onehot;
                        win_idx   <= pick_idx;
                        fact_n_q  <= pick_n;
                        fact_go_q <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.fact_done) begin
                        resp_nf_q    <= bus.fact_nf;
                        resp_err_q   <= bus.fact_err;
                        resp_valid_q <= grant_q;
                        state        <= RESP;
                    end else if (wait_expired) begin
                        fact_abort_q <= 1'b1;
                        resp_nf_q    <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= grant_q;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    grant_q <= '0;
                    rr      <= (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_nf    = resp_nf_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.fact_n     = fact_n_q;
    assign bus.fact_go    = fact_go_q;
    assign bus.fact_abort = fact_abort_q;
endmodule

// File: tb/tb_fact_arb.sv
// tb_fact_arb: scoreboard bench for fact_arb with a stub factorial engine.
// Stimulus pushes hand-computed expected responses; a negedge monitor pops
// and compares them whenever fact_go or resp_valid is presented.
`timescale 1ns/1ps
module tb_fact_arb;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fact_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    fact_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned      idx;
        logic [WIDTH-1:0] n;
        logic [WIDTH-1:0] nf;
        logic             err;
        logic             abort;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int unsigned      pend   [NREQ] = '{default: 0};
    int unsigned      served [NREQ] = '{default: 0};
    logic [WIDTH-1:0] ops    [NREQ] = '{default: '0};
    int unsigned      eng_lat  = 2;
    bit               eng_hang = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stub engine result: 32-bit overflow reports err with nf=0.
    function automatic logic [WIDTH:0] fact_ref(input logic [WIDTH-1:0] n);
        logic [63:0] acc;
        acc = 64'd1;
        for (int unsigned k = 2; k <= n; k++) begin
            acc = acc * k;
            if (acc > 64'hFFFF_FFFF) return {1'b1, {WIDTH{1'b0}}};
        end
        return {1'b0, acc[WIDTH-1:0]};
    endfunction

    // Stub engine: done eng_lat cycles after go is seen; reset by rst or abort.
    logic        eng_busy = 1'b0;
    int unsigned eng_cnt  = 0;
    logic [WIDTH-1:0] eng_n = '0;
    always @(posedge clk) begin
        if (rst || bus.fact_abort) begin
            eng_busy      <= 1'b0;
            bus.fact_done <= 1'b0;
            bus.fact_err  <= 1'b0;
            bus.fact_nf   <= '0;
        end else begin
            bus.fact_done <= 1'b0;
            if (bus.fact_go) begin
                eng_busy <= 1'b1;
                eng_cnt  <= eng_lat;
                eng_n    <= bus.fact_n;
            end else if (eng_busy && !eng_hang) begin
                if (eng_cnt == 0) begin
                    eng_busy                   <= 1'b0;
                    bus.fact_done              <= 1'b1;
                    {bus.fact_err, bus.fact_nf} <= fact_ref(eng_n);
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    // Requesters: hold req while requests remain, drop after each resp_valid.
    always @(negedge clk) begin
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!rst && bus.resp_valid[i]) served[i] = served[i] + 1;
            bus.req[i] = (pend[i] > served[i]);
            bus.req_n[i*WIDTH +: WIDTH] = ops[i];
        end
    end

    // Monitor: compare engine issue and responses against the scoreboard.
    logic        go_prev = 1'b0;
    logic        rv_prev = 1'b0;
    int unsigned go_age  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            go_prev = 1'b0;
            rv_prev = 1'b0;
            go_age  = 0;
        end else begin
            if (bus.fact_go) begin
                check("go_single", 64'(go_prev), 64'd0);
                if (exp_q.size() == 0) begin
                    check("go_expected", 64'd1, 64'd0);
                end else begin
                    check("go_grant", 64'(bus.grant), 64'(1 << exp_q[0].idx));
                    check("go_fact_n", 64'(bus.fact_n), 64'(exp_q[0].n));
                end
                go_age = 0;
            end else begin
                go_age++;
            end
            if (bus.resp_valid != '0) begin
                check("resp_single", 64'(rv_prev), 64'd0);
                if (exp_q.size() == 0) begin
                    check("resp_expected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_valid", 64'(bus.resp_valid), 64'(1 << e.idx));
                    check("resp_nf", 64'(bus.resp_nf), 64'(e.nf));
                    check("resp_err", 64'(bus.resp_err), 64'(e.err));
                    check("resp_grant", 64'(bus.grant), 64'(1 << e.idx));
                    check("resp_fact_n_held", 64'(bus.fact_n), 64'(e.n));
                    check("resp_abort", 64'(bus.fact_abort), 64'(e.abort));
                    // Abort follows TIMEOUT full WAIT cycles after the go cycle.
                    if (e.abort) check("abort_delay", 64'(go_age), 64'(TIMEOUT + 1));
                end
            end else if (bus.fact_abort) begin
                check("abort_without_resp", 64'd1, 64'd0);
            end
            go_prev = bus.fact_go;
            rv_prev = |bus.resp_valid;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int unsigned idx, input logic [WIDTH-1:0] n,
                       input logic [WIDTH-1:0] nf, input logic err, input logic abort);
        exp_t e;
        e.idx = idx; e.n = n; e.nf = nf; e.err = err; e.abort = abort;
        ops[idx]  = n;
        pend[idx] = pend[idx] + 1;
        exp_q.push_back(e);
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = (exp_q.size() == 0);
        for (int i = 0; i < int'(NREQ); i++) if (pend[i] > served[i]) idle = 1'b0;
        return idle;
    endfunction

    task automatic drain(input int unsigned budget, input string name);
        for (int unsigned c = 0; c < budget; c++) begin
            @(negedge clk);
            if (all_idle()) break;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_go(input int unsigned budget);
        bit seen;
        seen = 1'b0;
        for (int unsigned c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (bus.fact_go) seen = 1'b1;
        end
        check("go_seen", 64'(seen), 64'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_grant"},      64'(bus.grant),      64'd0);
        check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_resp_nf"},    64'(bus.resp_nf),    64'd0);
        check({tag, "_resp_err"},   64'(bus.resp_err),   64'd0);
        check({tag, "_fact_n"},     64'(bus.fact_n),     64'd0);
        check({tag, "_fact_go"},    64'(bus.fact_go),    64'd0);
        check({tag, "_fact_abort"}, 64'(bus.fact_abort), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < int'(NREQ); i++) pend[i] = served[i];
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int unsigned rv_seen;

        // Reset state
        do_reset();

        // Single request n=5; req drop and operand change after capture are ignored
        sync();
        add(1, 5, 120, 1'b0, 1'b0);
        wait_go(20);
        pend[1] = served[1];
        ops[1]  = 9;
        drain(50, "single_drain");

        // Simultaneous 0101 from reset: 0 first then 2, rr left at 3
        do_reset();
        sync();
        add(0, 3, 6, 1'b0, 1'b0);
        add(2, 4, 24, 1'b0, 1'b0);
        drain(80, "simul_drain");

        // rr=3 means requester 3 beats requester 0
        sync();
        add(3, 2, 2, 1'b0, 1'b0);
        add(0, 1, 1, 1'b0, 1'b0);
        drain(80, "rr3_drain");

        // Fairness: 1111 with requester 0 held for a second service
        do_reset();
        sync();
        add(0, 1, 1, 1'b0, 1'b0);
        add(1, 2, 2, 1'b0, 1'b0);
        add(2, 3, 6, 1'b0, 1'b0);
        add(3, 4, 24, 1'b0, 1'b0);
        add(0, 1, 1, 1'b0, 1'b0);
        drain(200, "fair_drain");

        // Engine overflow error, then a clean request; zero engine latency too
        eng_lat = 5;
        sync();
        add(1, 13, 0, 1'b1, 1'b0);
        drain(60, "err_drain");
        eng_lat = 0;
        sync();
        add(1, 4, 24, 1'b0, 1'b0);
        drain(60, "after_err_drain");

        // Reset in WAIT drops the request with no response
        eng_lat = 20;
        sync();
        add(2, 5, 120, 1'b0, 1'b0);
        wait_go(20);
        @(negedge clk);
        do_reset();
        rv_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.resp_valid != '0) rv_seen++;
        end
        check("no_resp_after_reset", 64'(rv_seen), 64'd0);
        eng_lat = 2;
        sync();
        add(3, 1, 1, 1'b0, 1'b0);
        drain(60, "post_reset_drain");

`ifdef FACT_ARB_TIMEOUT_EN
        // Never-done engine: abort, nf=0, err=1; rr advances, next service normal
        eng_hang = 1'b1;
        sync();
        add(1, 7, 0, 1'b1, 1'b1);
        drain(100, "timeout_drain");
        eng_hang = 1'b0;
        sync();
        add(1, 4, 24, 1'b0, 1'b0);
        drain(60, "after_timeout_drain");
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/fact_arb.md
Name: fact_arb

Overview:
- Round-robin arbiter and sequencer that shares one factorial engine (go/done/err/nf interface) among NREQ requesters.
- Sits between CPU-side or peripheral-side requesters and a single engine instance. All engine sequencing lives here.
- Per request: capture operand, issue a go pulse, wait for done, return result and error flag to the winning requester, then rotate priority.

Parameters:
- WIDTH, 32, operand/result width; must match engine WIDTH
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 1024, engine watchdog limit in cycles (used only with FACT_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester request level; held high until that requester's resp_valid
- req_n  in  NREQ*WIDTH  packed operands; slice i = req_n[i*WIDTH +: WIDTH]
- grant  out  NREQ  one-hot; marks the requester currently being served
- resp_valid  out  NREQ  one-cycle pulse to the served requester
- resp_nf  out  WIDTH  result; valid while any resp_valid is high
- resp_err  out  1  error flag; valid while any resp_valid is high
- fact_n  out  WIDTH  operand to engine
- fact_go  out  1  engine start pulse
- fact_done  in  1  engine completion
- fact_err  in  1  engine error (qualified by fact_done)
- fact_nf  in  WIDTH  engine result (qualified by fact_done)
- fact_abort  out  1  engine abort pulse; top level ORs it into engine rst

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, rr pointer=0.
  - grant, resp_valid, resp_nf, resp_err, fact_n, fact_go, fact_abort all 0.
  - Reset overrides every state, including mid-WAIT. An in-flight request is dropped with no response; the requester must re-request.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req is nonzero, pick the first set bit at or after rr (wrapping modulo NREQ).
  - Register grant one-hot and fact_n = that requester's slice, then go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE:
  - fact_go=1 for exactly this one cycle, then go to WAIT.
  - fact_n is held constant from ISSUE through RESP.
- WAIT:
  - fact_go=0. On fact_done=1: latch resp_nf=fact_nf and resp_err=fact_err, then go to RESP.
  - fact_done is ignored in every other state. A done seen in the same cycle as go is not accepted.
- RESP:
  - resp_valid[winner]=1 for one cycle.
  - rr = (winner+1) mod NREQ.
  - Next state IDLE; grant clears on entry to IDLE.
- Latency:
  - Request seen in IDLE at cycle t: grant from t+1, fact_go at t+1.
  - fact_done at cycle d: resp_valid at d+1.
  - Minimum request-to-response time is 3 cycles plus engine latency. Back-to-back service reaches a new ISSUE 2 cycles after RESP.
- Only one request is outstanding at the engine at any time. Requests arriving while not in IDLE wait.
- A req drop while granted is ignored: service completes and resp_valid is still pulsed.
- req_n changes after capture have no effect.
- Simultaneous requests are resolved by rr. Every asserted requester is served within NREQ grants.
- resp_nf and resp_err hold their last values between responses.

Optional Feature:
- Macro: FACT_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter, width $clog2(TIMEOUT+1), clears on ISSUE.
  - If the count reaches TIMEOUT with no fact_done: pulse fact_abort for 1 cycle, set resp_nf=0 and resp_err=1, go to RESP.
  - This path advances rr normally.
  - fact_done arriving in the same cycle the limit is reached wins: the normal result is returned and there is no abort.
- Undefined: no counter; fact_abort is tied to 0; WAIT lasts until fact_done.

Test Plan:
- Single request, WIDTH=32: req[1]=1, n=5 -> grant=0010; one fact_go pulse with fact_n=5; resp_valid=0010 one cycle after done; resp_nf=120, resp_err=0.
- Simultaneous requests: req=0101 from reset, n0=3, n2=4 -> requester 0 served first (nf=6), then requester 2 (nf=24); rr ends at 3.
- Round-robin fairness: req=1111 held continuously -> grant order 0,1,2,3,0; each resp_valid pulse exactly one cycle.
- Engine error: n=13 (13! exceeds 2^32) -> resp_err=1 with resp_valid; following request n=4 returns nf=24 with err=0.
- Reset mid-WAIT: assert rst during WAIT -> next cycle all outputs 0, state IDLE, no resp_valid; a fresh req[3] with n=1 returns nf=1.
- With FACT_ARB_TIMEOUT_EN, TIMEOUT=16, engine stubbed never-done -> fact_abort pulse 16 WAIT cycles after go; resp_valid with resp_nf=0, resp_err=1.
